ram_loader: RTL

- Bootstrap loader that sits directly upstream of the 16K-word data RAM and drives its in/load/address inputs.
- Accepts a byte stream over a valid/ready handshake, assembles big-endian 16-bit words and writes them to consecutive RAM addresses from a programmable base.
- Holds the CPU off the RAM port while active (cpu_hold) and pulses done when the requested word count has been written.

---
 rtl/ram_loader_pkg.sv | 22 ++
 rtl/ram_loader_if.sv | 21 ++
 rtl/ram_loader_byte_pair_assembler.sv | 27 ++
 rtl/ram_loader.sv | 123 ++++++++++++
 4 files changed

// File: rtl/ram_loader_pkg.sv
// Shared constants and state encoding for the RAM bootstrap loader and its RAM neighbours.
package ram_loader_pkg;

   localparam int RAM_ADDR_W = 14;
   localparam int WORD_W     = 16;
   localparam int BYTE_W     = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HI    = 3'd1,
      ST_LO    = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Words arrive big-endian: first byte is the upper half.
   function automatic logic [WORD_W-1:0] pack_be(input logic [BYTE_W-1:0] hi,
                                                 input logic [BYTE_W-1:0] lo);
      return {hi, lo};
   endfunction

endpackage

// File: rtl/ram_loader_if.sv
// Byte stream into the loader and the RAM write port out of it.
interface ram_loader_if #(parameter int ADDR_W = ram_loader_pkg::RAM_ADDR_W);
   import ram_loader_pkg::*;

   // A byte transfers on a rising edge where byte_valid && byte_ready are both high;
   // byte_ready never looks at byte_valid, and byte_valid may drop without a transfer.
   logic              byte_valid;
   logic [BYTE_W-1:0] byte_data;
   logic              byte_ready;

   logic [WORD_W-1:0] ram_in;
   logic              ram_load;
   logic [ADDR_W-1:0] ram_address;

   modport master (input  byte_valid, byte_data,
                   output byte_ready, ram_in, ram_load, ram_address);

   modport slave  (output byte_valid, byte_data,
                   input  byte_ready, ram_in, ram_load, ram_address);

endinterface

// File: rtl/ram_loader_byte_pair_assembler.sv
// Holds the high byte of a word and presents {hi, current byte} for the low-byte cycle.
module byte_pair_assembler
   import ram_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              load_hi,
   input  logic [BYTE_W-1:0] byte_data,
   output logic [WORD_W-1:0] word
);

   logic [BYTE_W-1:0] hi;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi <= '0;
      end else if (clear) begin
         hi <= '0;
      end else if (load_hi) begin
         hi <= byte_data;
      end
   end

   assign word = pack_be(hi, byte_data);

endmodule

// File: rtl/ram_loader.sv
// Bootstrap loader: turns a byte stream into consecutive 16-bit RAM writes while holding the CPU off the RAM.
module ram_loader
   import ram_loader_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W,
   parameter int CNT_W  = 15
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_count,
   input  logic              abort,
   ram_loader_if.master      bus,
   output logic              cpu_hold,
   output logic              done,
   output logic              busy,
   output logic [2:0]        fsm_state
);

   // One full pass of the address space is the most a single load may write.
   localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(2 ** ADDR_W);

   state_t             state;
   logic [ADDR_W-1:0]  addr;
   logic [CNT_W-1:0]   remaining;
   logic [CNT_W-1:0]   start_count;
   logic [WORD_W-1:0]  word;
   logic               hs;
   logic               load_hi;

   assign hs          = bus.byte_valid & bus.byte_ready;
   assign load_hi     = hs & (state == ST_HI) & ~abort;
   assign start_count = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
   assign fsm_state   = state;

   byte_pair_assembler u_asm (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (abort),
      .load_hi   (load_hi),
      .byte_data (bus.byte_data),
      .word      (word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         addr            <= '0;
         remaining       <= '0;
         bus.ram_in      <= '0;
         bus.ram_load    <= 1'b0;
         bus.ram_address <= '0;
         bus.byte_ready  <= 1'b0;
         cpu_hold        <= 1'b0;
         done            <= 1'b0;
         busy            <= 1'b0;
      end else begin
         bus.ram_load <= 1'b0;
         done         <= 1'b0;
         if (abort) begin
            // A write already on the RAM port this cycle still lands; everything else is dropped.
            state          <= ST_IDLE;
            bus.byte_ready <= 1'b0;
            cpu_hold       <= 1'b0;
            busy           <= 1'b0;
         end else begin
            case (state)
               ST_IDLE, ST_DONE: begin
                  if (start) begin
                     if (word_count == '0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                     end else begin
                        state          <= ST_HI;
                        addr           <= base_addr;
                        remaining      <= start_count;
                        bus.byte_ready <= 1'b1;
                        cpu_hold       <= 1'b1;
                        busy           <= 1'b1;
                     end
                  end
               end
               ST_HI: begin
                  if (hs) begin
                     state <= ST_LO;
                  end
               end
               ST_LO: begin
                  if (hs) begin
                     state           <= ST_WRITE;
                     bus.ram_in      <= word;
                     bus.ram_address <= addr;
                     bus.ram_load    <= 1'b1;
                     bus.byte_ready  <= 1'b0;
                  end
               end
               ST_WRITE: begin
                  addr      <= addr + ADDR_W'(1);
                  remaining <= remaining - CNT_W'(1);
                  if (remaining == CNT_W'(1)) begin
                     state    <= ST_DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                     busy     <= 1'b0;
                  end else begin
                     state          <= ST_HI;
                     bus.byte_ready <= 1'b1;
                  end
               end
               default: begin
                  state          <= ST_IDLE;
                  bus.byte_ready <= 1'b0;
                  cpu_hold       <= 1'b0;
                  busy           <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
